// File: rtl/motor_pwm_sequencer.sv
// ---------------------------------------------------------------------------
// motor_pwm_sequencer
//
// This block provides the shared timebase and configuration control for one or
// more motor_pwm_phase stages. It owns the free-running PWM counter and handles
// start, stop and fault sequencing. Period, duty and deadband are double
// buffered: a host write lands in a shadow set, and the shadow set moves to the
// active registers only at a period boundary. While the block is IDLE the move
// happens immediately instead.
//
// Optional feature: define MOTOR_PWM_SEQ_RAMP_EN to enable duty ramping. With
// it, the shadow duty is treated as a target. At each wrap, the active duty
// steps toward that target by at most RAMP_STEP. The shadow stays pending
// until the target is reached. In IDLE the target is applied directly.
//
// Ports
//   clk_i            system clock, rising edge
//   reset_i          asynchronous active-high reset
//   cfg_valid_i      host offers a config set
//   cfg_ready_o      shadow empty, a config set can be accepted
//   cfg_period_i     requested period (clk cycles)
//   cfg_duty_i       requested duty (counts)
//   cfg_deadband_i   requested deadband (counts)
//   start_i          pulse: begin PWM
//   stop_i           pulse: finish the current period, then halt
//   fault_i          level: immediate halt, latches fault_latched_o
//   fault_clr_i      pulse: clear the latched fault (only while fault_i is low)
//   pwm_counter_o    shared counter, 0 .. pwm_period_o-1
//   pwm_period_o     active period
//   pwm_duty_o       active duty
//   pwm_deadband_o   active deadband
//   pwm_enable_o     enable to the phase stages
//   period_strobe_o  one-cycle pulse while the counter shows pwm_period_o-1
//   fault_latched_o  sticky fault flag
// ---------------------------------------------------------------------------
module motor_pwm_sequencer #(
    parameter int SIZE      = 16,
    parameter int RAMP_STEP = 8
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            cfg_valid_i,
    output logic            cfg_ready_o,
    input  logic [SIZE-1:0] cfg_period_i,
    input  logic [SIZE-1:0] cfg_duty_i,
    input  logic [SIZE-1:0] cfg_deadband_i,
    input  logic            start_i,
    input  logic            stop_i,
    input  logic            fault_i,
    input  logic            fault_clr_i,
    output logic [SIZE-1:0] pwm_counter_o,
    output logic [SIZE-1:0] pwm_period_o,
    output logic [SIZE-1:0] pwm_duty_o,
    output logic [SIZE-1:0] pwm_deadband_o,
    output logic            pwm_enable_o,
    output logic            period_strobe_o,
    output logic            fault_latched_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOPPING} state_e;

    typedef struct packed {
        logic [SIZE-1:0] period;
        logic [SIZE-1:0] duty;
        logic [SIZE-1:0] deadband;
    } cfg_t;

    localparam logic [SIZE-1:0] MIN_PERIOD = SIZE'(2);

    if (RAMP_STEP < 1) begin : g_step_chk
        $error("RAMP_STEP must be at least 1");
    end

    state_e          state_q, state_d;
    logic [SIZE-1:0] cnt_q, cnt_d;
    cfg_t            active_q, active_d;
    cfg_t            shadow_q, shadow_d;
    logic            pend_q, pend_d;
    logic            strobe_q, strobe_d;
    logic            fault_q, fault_d;

    logic            wrap;
    logic            xfer;
    logic            apply;
    logic [SIZE-1:0] cap_period;
    logic [SIZE-1:0] cap_duty;
    logic [SIZE-1:0] cap_deadband;

    // Clamp the incoming set at capture time. The period is clamped first
    // because the duty and deadband limits both depend on it.
    always_comb begin
        cap_period   = (cfg_period_i < MIN_PERIOD) ? MIN_PERIOD : cfg_period_i;
        cap_duty     = (cfg_duty_i > cap_period) ? cap_period : cfg_duty_i;
        cap_deadband = (cfg_deadband_i > (cap_period >> 1)) ? (cap_period >> 1)
                                                            : cfg_deadband_i;
    end

    assign wrap  = (state_q != ST_IDLE) && (cnt_q == active_q.period - SIZE'(1));
    assign xfer  = cfg_valid_i && !pend_q;
    assign apply = pend_q && ((state_q == ST_IDLE) || wrap);

`ifdef MOTOR_PWM_SEQ_RAMP_EN
    localparam logic [SIZE-1:0] STEP = SIZE'(RAMP_STEP);
    logic [SIZE-1:0] ramp_duty;

    // Move one bounded step toward the target. Once the remaining distance is
    // within one step, land exactly on the target.
    always_comb begin
        ramp_duty = shadow_q.duty;
        if (shadow_q.duty > active_q.duty) begin
            if (shadow_q.duty - active_q.duty > STEP) ramp_duty = active_q.duty + STEP;
        end else begin
            if (active_q.duty - shadow_q.duty > STEP) ramp_duty = active_q.duty - STEP;
        end
    end
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (fault_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:     if (start_i && !fault_q) state_d = ST_RUN;
                ST_RUN:      if (stop_i) state_d = ST_STOPPING;
                // A start arriving together with a stop does not cancel it.
                ST_STOPPING: if (start_i && !stop_i) state_d = ST_RUN;
                             else if (wrap)          state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        pwm_enable_o = (state_q != ST_IDLE);
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;

        if (xfer) begin
            shadow_d = '{period: cap_period, duty: cap_duty, deadband: cap_deadband};
            pend_d   = 1'b1;
        end

        // xfer and apply never coincide: xfer needs !pend_q, apply needs pend_q.
        if (apply) begin
`ifdef MOTOR_PWM_SEQ_RAMP_EN
            active_d.period   = shadow_q.period;
            active_d.deadband = shadow_q.deadband;
            active_d.duty     = (state_q == ST_IDLE) ? shadow_q.duty : ramp_duty;
            pend_d            = (active_d.duty != shadow_q.duty);
`else
            active_d = shadow_q;
            pend_d   = 1'b0;
`endif
        end

        // The counter shows 0 on the first RUN cycle and is held at 0 in IDLE.
        if ((state_q == ST_IDLE) || (state_d == ST_IDLE) || wrap) cnt_d = '0;
        else                                                     cnt_d = cnt_q + SIZE'(1);

        // Decode against next-cycle values so the registered strobe lines up
        // with the cycle that shows period-1.
        strobe_d = (state_d != ST_IDLE) && (cnt_d == active_d.period - SIZE'(1));

        if (fault_i)          fault_d = 1'b1;
        else if (fault_clr_i) fault_d = 1'b0;
        else                  fault_d = fault_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            active_q <= '{period: MIN_PERIOD, duty: '0, deadband: '0};
            shadow_q <= '0;
            pend_q   <= 1'b0;
            strobe_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            strobe_q <= strobe_d;
            fault_q  <= fault_d;
        end
    end

    assign cfg_ready_o     = !pend_q;
    assign pwm_counter_o   = cnt_q;
    assign pwm_period_o    = active_q.period;
    assign pwm_duty_o      = active_q.duty;
    assign pwm_deadband_o  = active_q.deadband;
    assign period_strobe_o = strobe_q;
    assign fault_latched_o = fault_q;

endmodule

// File: tb/tb_motor_pwm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_motor_pwm_sequencer
//
// Directed bench for motor_pwm_sequencer. Inputs are driven 1 ns after each
// rising edge. Outputs are sampled at the same point, after the edge.
// The duty-ramp checks are built in only when MOTOR_PWM_SEQ_RAMP_EN is
// defined. The single-step duty checks are built in only when it is not.
// ---------------------------------------------------------------------------
module tb_motor_pwm_sequencer;

    localparam int SIZE = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [SIZE-1:0] cfg_period;
    logic [SIZE-1:0] cfg_duty;
    logic [SIZE-1:0] cfg_deadband;
    logic            start;
    logic            stop;
    logic            fault;
    logic            fault_clr;
    logic [SIZE-1:0] pwm_counter;
    logic [SIZE-1:0] pwm_period;
    logic [SIZE-1:0] pwm_duty;
    logic [SIZE-1:0] pwm_deadband;
    logic            pwm_enable;
    logic            period_strobe;
    logic            fault_latched;

    int checks = 0;
    int errors = 0;

    motor_pwm_sequencer #(.SIZE(SIZE), .RAMP_STEP(8)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .cfg_valid_i     (cfg_valid),
        .cfg_ready_o     (cfg_ready),
        .cfg_period_i    (cfg_period),
        .cfg_duty_i      (cfg_duty),
        .cfg_deadband_i  (cfg_deadband),
        .start_i         (start),
        .stop_i          (stop),
        .fault_i         (fault),
        .fault_clr_i     (fault_clr),
        .pwm_counter_o   (pwm_counter),
        .pwm_period_o    (pwm_period),
        .pwm_duty_o      (pwm_duty),
        .pwm_deadband_o  (pwm_deadband),
        .pwm_enable_o    (pwm_enable),
        .period_strobe_o (period_strobe),
        .fault_latched_o (fault_latched)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic offer(input int p, input int d, input int db);
        cfg_valid    = 1'b1;
        cfg_period   = SIZE'(p);
        cfg_duty     = SIZE'(d);
        cfg_deadband = SIZE'(db);
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_period = '0; cfg_duty = '0; cfg_deadband = '0;
        start = 1'b0; stop = 1'b0; fault = 1'b0; fault_clr = 1'b0;
        #3;
        chk("rst_counter", pwm_counter, 0);
        chk("rst_period", pwm_period, 2);
        chk("rst_duty", pwm_duty, 0);
        chk("rst_deadband", pwm_deadband, 0);
        chk("rst_enable", pwm_enable, 0);
        chk("rst_strobe", period_strobe, 0);
        chk("rst_fault", fault_latched, 0);
        chk("rst_ready", cfg_ready, 1);
        reset = 1'b0;
        tick();

        // ---- config in IDLE, start, first full period ----
        offer(1000, 500, 33); tick(); cfg_valid = 1'b0;
        chk("idle_ready_busy", cfg_ready, 0);
        tick();
        chk("idle_period", pwm_period, 1000);
        chk("idle_duty", pwm_duty, 500);
        chk("idle_deadband", pwm_deadband, 33);
        chk("idle_ready_free", cfg_ready, 1);
        chk("idle_enable", pwm_enable, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("start_enable", pwm_enable, 1);
        chk("start_counter", pwm_counter, 0);
        repeat (998) tick();
        chk("cnt_998", pwm_counter, 998);
        chk("strobe_998", period_strobe, 0);
        tick();
        chk("cnt_999", pwm_counter, 999);
        chk("strobe_999", period_strobe, 1);
        tick();
        chk("wrap_counter", pwm_counter, 0);
        chk("wrap_strobe", period_strobe, 0);
        chk("wrap_enable", pwm_enable, 1);

        // ---- duty update while running applies at the wrap ----
`ifndef MOTOR_PWM_SEQ_RAMP_EN
        repeat (400) tick();
        offer(1000, 250, 33); tick(); cfg_valid = 1'b0;
        chk("run_ready_busy", cfg_ready, 0);
        chk("run_duty_old", pwm_duty, 500);
        repeat (598) tick();
        chk("run_cnt_999", pwm_counter, 999);
        chk("run_duty_999", pwm_duty, 500);
        tick();
        chk("run_wrap_cnt", pwm_counter, 0);
        chk("run_duty_new", pwm_duty, 250);
        tick();
        chk("run_cnt_1", pwm_counter, 1);
        chk("run_ready_free", cfg_ready, 1);
`else
        repeat (1001) tick();
`endif

        // ---- stop finishes the current period ----
        repeat (299) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop_cnt", pwm_counter, 301);
        chk("stop_enable", pwm_enable, 1);
        repeat (698) tick();
        chk("stop_cnt_999", pwm_counter, 999);
        chk("stop_enable_999", pwm_enable, 1);
        tick();
        chk("stop_done_enable", pwm_enable, 0);
        chk("stop_done_cnt", pwm_counter, 0);
        repeat (5) tick();
        chk("idle_cnt_held", pwm_counter, 0);

        // ---- start during STOPPING cancels the stop ----
        start = 1'b1; tick(); start = 1'b0;
        repeat (10) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("cancel_cnt", pwm_counter, 12);
        repeat (987) tick();
        tick();
        chk("cancel_wrap_cnt", pwm_counter, 0);
        chk("cancel_enable", pwm_enable, 1);

        // ---- start together with stop: the stop wins ----
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        repeat (998) tick();
        chk("both_cnt_999", pwm_counter, 999);
        tick();
        chk("both_enable", pwm_enable, 0);

        // ---- fault handling ----
        start = 1'b1; tick(); start = 1'b0;
        repeat (123) tick();
        chk("pre_fault_cnt", pwm_counter, 123);
        fault = 1'b1; tick();
        chk("fault_enable", pwm_enable, 0);
        chk("fault_cnt", pwm_counter, 0);
        chk("fault_latched", fault_latched, 1);
        fault_clr = 1'b1; tick(); fault_clr = 1'b0;
        chk("fault_beats_clr", fault_latched, 1);
        fault = 1'b0; start = 1'b1; tick(); start = 1'b0;
        chk("fault_start_ignored", pwm_enable, 0);
        fault_clr = 1'b1; tick(); fault_clr = 1'b0;
        chk("fault_cleared", fault_latched, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_enable", pwm_enable, 1);
        chk("restart_cnt", pwm_counter, 0);

        // ---- clamping of an out-of-range set ----
`ifndef MOTOR_PWM_SEQ_RAMP_EN
        offer(1, 1500, 900); tick(); cfg_valid = 1'b0;
        repeat (998) tick();
        tick();
        chk("clamp_period", pwm_period, 2);
        chk("clamp_duty", pwm_duty, 2);
        chk("clamp_deadband", pwm_deadband, 1);
        chk("clamp_cnt0", pwm_counter, 0);
        chk("clamp_strobe0", period_strobe, 0);
        tick();
        chk("clamp_cnt1", pwm_counter, 1);
        chk("clamp_strobe1", period_strobe, 1);
        tick();
        chk("clamp_cnt_wrap", pwm_counter, 0);
        chk("clamp_strobe_wrap", period_strobe, 0);
`endif

        // ---- asynchronous reset mid-run discards a pending set ----
        offer(300, 100, 10); tick(); cfg_valid = 1'b0;
        chk("pre_reset_ready", cfg_ready, 0);
        #2; reset = 1'b1; #1;
        chk("arst_cnt", pwm_counter, 0);
        chk("arst_period", pwm_period, 2);
        chk("arst_enable", pwm_enable, 0);
        chk("arst_ready", cfg_ready, 1);
        reset = 1'b0;
        tick();
        chk("post_reset_period", pwm_period, 2);

`ifdef MOTOR_PWM_SEQ_RAMP_EN
        // ---- duty ramp: direct apply in IDLE, bounded steps while running ----
        offer(500, 500, 0); tick(); cfg_valid = 1'b0;
        tick();
        chk("ramp_idle_direct", pwm_duty, 500);
        start = 1'b1; tick(); start = 1'b0;
        offer(500, 100, 0); tick(); cfg_valid = 1'b0;
        repeat (498) tick();
        tick();
        chk("ramp_wrap1_cnt", pwm_counter, 0);
        chk("ramp_wrap1_duty", pwm_duty, 492);
        chk("ramp_wrap1_ready", cfg_ready, 0);
        repeat (48 * 500) tick();
        chk("ramp_wrap49_duty", pwm_duty, 108);
        chk("ramp_wrap49_ready", cfg_ready, 0);
        repeat (500) tick();
        chk("ramp_wrap50_duty", pwm_duty, 100);
        chk("ramp_wrap50_ready", cfg_ready, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
